axi_burst_reader: RTL
=====================

Name: axi_burst_reader

Overview:
- AXI4 full read master; the read-side counterpart of the burst writer IP.
- On a rising edge of INIT_AXI_TXN it issues NUM_BURSTS INCR read bursts of BURST_LEN beats, starting at BASE_ADDR.
- It checks every returned beat against the writer's incrementing data pattern and forwards each beat on a simple valid-qualified output.
- Reports completion on TXN_DONE and a sticky ERROR flag; sits in the block design beside the writer, both mastering the same slave memory.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width in bits; 32 or 64 only.
- BURST_LEN, 16, beats per burst; 1..256; BURST_LEN*DATA_WIDTH/8 <= 4096.
- NUM_BURSTS, 64, bursts per transaction; >= 1.
- BASE_ADDR, 32'h4000_0000, start byte address; must be 4 KiB aligned.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- INIT_AXI_TXN  in  1  start request; acted on at its rising edge only.
- TXN_DONE  out  1  high from run completion until the next accepted start.
- ERROR  out  1  sticky error; cleared on the next accepted start.
- M_AXI_ARADDR  out  ADDR_WIDTH  burst start address.
- M_AXI_ARLEN  out  8  BURST_LEN-1.
- M_AXI_ARSIZE  out  3  log2(DATA_WIDTH/8).
- M_AXI_ARBURST  out  2  2'b01 (INCR).
- M_AXI_ARVALID  out  1  address valid.
- M_AXI_ARREADY  in  1  address accept.
- M_AXI_RDATA  in  DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RLAST  in  1  last beat of the burst.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.
- DOUT  out  DATA_WIDTH  registered copy of the accepted RDATA.
- DOUT_VALID  out  1  one-cycle strobe per accepted beat.

Behaviour:
- Reset (ARESET=1 at an ACLK edge):
  - All outputs go to 0; M_AXI_ARLEN, M_AXI_ARSIZE and M_AXI_ARBURST are constants.
  - The FSM goes to IDLE; all counters clear; the INIT edge-detect register clears.
  - Reset mid-burst abandons the run immediately, including dropping ARVALID; no completion is reported.
- Start detect: start = INIT_AXI_TXN & ~init_q, where init_q is INIT_AXI_TXN registered. A level held high gives exactly one start.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE: on start, clear ERROR, TXN_DONE, burst_idx and beat_cnt, then go to ADDR.
  - ADDR:
    - ARVALID=1; ARADDR = BASE_ADDR + burst_idx*BURST_LEN*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH.
    - ARVALID and ARADDR stay stable until ARREADY. On the handshake, ARVALID drops the next cycle and the FSM goes to DATA.
    - Only one burst is outstanding at a time.
  - DATA:
    - RREADY=1. On each RVALID&RREADY: DOUT<=RDATA and DOUT_VALID=1 on the next cycle.
    - The expected value is global_beat+1, truncated to DATA_WIDTH; global_beat counts from 0 across the whole run.
    - On the final beat (beat_cnt==BURST_LEN-1): increment burst_idx. Go to DONE if this was burst NUM_BURSTS-1, otherwise go to ADDR.
  - DONE: TXN_DONE=1; RREADY=0; wait for start, then act as IDLE does on start.
- Error detect: ERROR is set the cycle after an accepted beat with any of:
  - RRESP[1]==1 (SLVERR or DECERR);
  - RDATA not equal to the expected value;
  - RLAST=1 on a non-final beat;
  - RLAST=0 on the final beat.
- Errors never abort the run. Beat counting is by the module's own count, not by RLAST.
- ERROR stays set through DONE until the next start.
- Start pulses arriving in ADDR or DATA are ignored.
- RVALID seen outside DATA is not accepted (RREADY=0) and is not flagged.
- A start in the same cycle as the final beat is ignored, because the FSM is still in DATA.
- Latency: ARVALID rises 1 cycle after the start edge is registered. TXN_DONE rises 1 cycle after the last accepted beat.
- Counter widths: beat_cnt is 8 bits; burst_idx is clog2(NUM_BURSTS+1) bits; global_beat is DATA_WIDTH bits and wraps.

Decomposition:
- Package axi_burst_reader_pkg holds:
  - the FSM state enum;
  - AXI_BURST_INCR = 2'b01 and RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - a function computing ARSIZE from DATA_WIDTH.
- One sub-module, axi_burst_reader_check:
  - inputs: the beat strobe, RDATA, RRESP, RLAST, is_final_beat and the run-start clear;
  - holds the expected-value counter and the sticky error register;
  - output: ERROR.

Test Plan:
- Defaults, memory preloaded with 1..1024 at BASE_ADDR, ARREADY/RVALID always high:
  - 64 AR handshakes at 0x4000_0000 + n*0x40;
  - 1024 DOUT_VALID strobes carrying 1..1024;
  - TXN_DONE=1, ERROR=0.
- Same run with random ARREADY/RVALID back-pressure (30% low) -> ARADDR/ARVALID stable while stalled, identical DOUT sequence, ERROR=0.
- Beat 37 returns 0xDEAD_BEEF -> ERROR set 1 cycle after that beat; run still finishes all 1024 beats; TXN_DONE=1.
- SLVERR on burst 5 beat 0 -> ERROR=1; RLAST asserted at beat 7 of burst 2 -> ERROR=1; neither changes the AR count (64).
- INIT held high for 50 cycles and re-pulsed mid-run -> exactly one run.
  - A fresh INIT pulse in DONE clears TXN_DONE and ERROR within 1 cycle and starts a second run.
- ARESET pulsed during burst 10 -> next cycle: all outputs 0, FSM IDLE.
  - A subsequent INIT produces a clean run starting at burst 0, with data 1..1024 and ERROR=0.

Source files
------------

// File: rtl/axi_burst_reader_pkg.sv
// Shared types and AXI constants for the burst reader.
package axi_burst_reader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // AxSIZE encoding for a full-width beat; only 32- and 64-bit buses are supported.
   function automatic logic [2:0] arsize_for(input int unsigned data_width);
      return (data_width == 64) ? 3'd3 : 3'd2;
   endfunction

endpackage

// File: rtl/axi_burst_reader_if.sv
// AXI4 read-channel bundle (AR + R) between the burst reader and the slave memory.
interface axi_burst_reader_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
   logic [7:0]            M_AXI_ARLEN;
   logic [2:0]            M_AXI_ARSIZE;
   logic [1:0]            M_AXI_ARBURST;
   logic                  M_AXI_ARVALID;
   logic                  M_AXI_ARREADY;
   logic [DATA_WIDTH-1:0] M_AXI_RDATA;
   logic [1:0]            M_AXI_RRESP;
   logic                  M_AXI_RLAST;
   logic                  M_AXI_RVALID;
   logic                  M_AXI_RREADY;

   modport master (
      output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
      output M_AXI_RREADY,
      input  M_AXI_ARREADY,
      input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
   );

   modport slave (
      input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
      input  M_AXI_RREADY,
      output M_AXI_ARREADY,
      output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
   );

endinterface

// File: rtl/axi_burst_reader_check.sv
// Beat checker: tracks the expected incrementing pattern and holds the sticky error flag.
module axi_burst_reader_check
   import axi_burst_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  beat,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  is_final_beat,
   output logic                  error
);

   logic [DATA_WIDTH-1:0] global_beat;
   logic                  resp_err_c;
   logic                  beat_err_c;

   // Any mismatch on an accepted beat: bad response, wrong data, or misplaced RLAST
   always_comb begin
      resp_err_c = 1'b0;
      case (rresp)
         RESP_OKAY, RESP_EXOKAY:   resp_err_c = 1'b0;
         RESP_SLVERR, RESP_DECERR: resp_err_c = 1'b1;
         default:                  resp_err_c = 1'b0;
      endcase
      beat_err_c = resp_err_c
                 | (rdata != (global_beat + DATA_WIDTH'(1)))
                 | (rlast != is_final_beat);
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         global_beat <= '0;
         error       <= 1'b0;
      end else if (beat) begin
         global_beat <= global_beat + DATA_WIDTH'(1);
         error       <= error | beat_err_c;
      end
   end

endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read master: reads NUM_BURSTS INCR bursts from BASE_ADDR and checks the writer's
// incrementing pattern, forwarding every accepted beat on DOUT/DOUT_VALID.
module axi_burst_reader
   import axi_burst_reader_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           BURST_LEN  = 16,
   parameter int unsigned           NUM_BURSTS = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  INIT_AXI_TXN,
   output logic                  TXN_DONE,
   output logic                  ERROR,
   output logic [DATA_WIDTH-1:0] DOUT,
   output logic                  DOUT_VALID,
   axi_burst_reader_if.master    m_axi
);

   localparam int unsigned BEAT_BYTES  = DATA_WIDTH / 8;
   localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
   localparam int unsigned BURST_IDX_W = $clog2(NUM_BURSTS + 1);
   localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
   localparam logic [BURST_IDX_W-1:0] LAST_BURST = BURST_IDX_W'(NUM_BURSTS - 1);
   localparam logic [2:0]  ARSIZE_C    = arsize_for(DATA_WIDTH);

   state_e                  state_q, state_d;
   logic                    init_q;
   logic [7:0]              beat_cnt;
   logic [BURST_IDX_W-1:0]  burst_idx;
   logic [ADDR_WIDTH-1:0]   araddr_q;
   logic                    arvalid_q;
   logic                    rready_q;
   logic                    txn_done_q;
   logic [DATA_WIDTH-1:0]   dout_q;
   logic                    dout_valid_q;

   logic start_c, run_start_c, ar_hs_c, beat_c, final_beat_c;

   assign start_c      = INIT_AXI_TXN & ~init_q;
   assign ar_hs_c      = arvalid_q & m_axi.M_AXI_ARREADY;
   assign beat_c       = rready_q & m_axi.M_AXI_RVALID;
   assign final_beat_c = (beat_cnt == LAST_BEAT);

   always_ff @(posedge ACLK) begin
      if (ARESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state; a start is only honoured when no run is in flight
   always_comb begin
      state_d     = state_q;
      run_start_c = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start_c) begin
               state_d     = ADDR;
               run_start_c = 1'b1;
            end
         end
         ADDR: if (ar_hs_c) state_d = DATA;
         DATA: begin
            if (beat_c && final_beat_c)
               state_d = (burst_idx == LAST_BURST) ? DONE : ADDR;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs follow the next state so they are registered yet aligned with it
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         init_q       <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         txn_done_q   <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         init_q       <= INIT_AXI_TXN;
         arvalid_q    <= (state_d == ADDR);
         rready_q     <= (state_d == DATA);
         txn_done_q   <= (state_d == DONE);
         dout_valid_q <= beat_c;
         if (beat_c) dout_q <= m_axi.M_AXI_RDATA;
      end
   end

   // Beat/burst counters; the burst address advances with the burst index
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         beat_cnt  <= '0;
         burst_idx <= '0;
         araddr_q  <= '0;
      end else if (run_start_c) begin
         beat_cnt  <= '0;
         burst_idx <= '0;
         araddr_q  <= BASE_ADDR;
      end else if (beat_c) begin
         if (final_beat_c) begin
            beat_cnt  <= '0;
            burst_idx <= burst_idx + BURST_IDX_W'(1);
            araddr_q  <= araddr_q + ADDR_WIDTH'(BURST_BYTES);
         end else begin
            beat_cnt  <= beat_cnt + 8'd1;
         end
      end
   end

   axi_burst_reader_check #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_check (
      .clk           (ACLK),
      .rst           (ARESET),
      .clr           (run_start_c),
      .beat          (beat_c),
      .rdata         (m_axi.M_AXI_RDATA),
      .rresp         (m_axi.M_AXI_RRESP),
      .rlast         (m_axi.M_AXI_RLAST),
      .is_final_beat (final_beat_c),
      .error         (ERROR)
   );

   assign m_axi.M_AXI_ARADDR  = araddr_q;
   assign m_axi.M_AXI_ARLEN   = LAST_BEAT;
   assign m_axi.M_AXI_ARSIZE  = ARSIZE_C;
   assign m_axi.M_AXI_ARBURST = AXI_BURST_INCR;
   assign m_axi.M_AXI_ARVALID = arvalid_q;
   assign m_axi.M_AXI_RREADY  = rready_q;
   assign TXN_DONE            = txn_done_q;
   assign DOUT                = dout_q;
   assign DOUT_VALID          = dout_valid_q;

endmodule
